// File: rtl/video_window_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_window_flush_ctrl
// Purpose  : Frame sequencer in front of video_stream_to_window. Admits whole
//            frames under an enable, forwards the stream with one cycle of
//            latency, and appends FLUSH_LINES synthetic zero lines so the
//            window line buffers drain before frame_end_o. Reports the line
//            count and line word count, and pulses on dropped or aborted frames.
// Revision : 1.0 - initial release
// ============================================================================
module video_window_flush_ctrl #(
    parameter  int PX_WIDTH      = 12,
    parameter  int PX_PER_CLK    = 4,
    parameter  int WIN_SIZE      = 3,
    parameter  int MAX_LINE_SIZE = 1936,
    parameter  int FLUSH_LINES   = WIN_SIZE / 2,
    localparam int LW_W          = $clog2((MAX_LINE_SIZE + PX_PER_CLK - 1) / PX_PER_CLK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
    input  logic [PX_PER_CLK-1:0]          px_data_val_i,
    input  logic                           line_start_i,
    input  logic                           line_end_i,
    input  logic                           frame_start_i,
    input  logic                           frame_end_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           busy_o,
    output logic                           flush_o,
    output logic                           frame_drop_o,
    output logic [15:0]                    line_cnt_o,
    output logic [LW_W-1:0]                line_words_o
);

    localparam int              FL_W       = (FLUSH_LINES > 1) ? $clog2(FLUSH_LINES) : 1;
    localparam logic [FL_W-1:0] C_FL_LAST  = FL_W'((FLUSH_LINES > 0) ? FLUSH_LINES - 1 : 0);
    localparam logic [LW_W-1:0] C_WCNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                          r_state;
    logic [PX_PER_CLK*PX_WIDTH-1:0]  r_px_data;
    logic [PX_PER_CLK-1:0]           r_px_val;
    logic                            r_ls;
    logic                            r_le;
    logic                            r_fs;
    logic                            r_fe;
    logic                            r_busy;
    logic                            r_flush;
    logic                            r_drop;
    logic [LW_W-1:0]                 r_wcnt;
    logic [LW_W-1:0]                 r_line_words;
    logic [LW_W-1:0]                 r_fl_word;
    logic [FL_W-1:0]                 r_fl_line;
    logic [15:0]                     r_lines;
    logic [15:0]                     r_line_cnt;
    logic [PX_PER_CLK-1:0]           r_last_mask;

    logic                            w_accept;
    logic                            w_drop;
    logic [LW_W-1:0]                 w_wcnt_next;
    logic [15:0]                     w_lines_next;
    logic                            w_fl_last_word;
    logic                            w_fl_last_line;

    // Decide whether the current input word belongs to an admitted frame.
    // In ACTIVE only a disabled new frame start is refused (abort to IDLE).
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            S_IDLE:   w_accept = frame_start_i & en_i;
            S_ACTIVE: w_accept = ~(frame_start_i & ~en_i);
            default:  w_accept = 1'b0;
        endcase
    end

    // Any frame start outside IDLE either aborts the running frame or is dropped
    assign w_drop = frame_start_i & (r_state != S_IDLE);

    // Word counter restarts at 1 on the line start word and saturates
    assign w_wcnt_next = line_start_i ? LW_W'(1) :
                         (r_wcnt == C_WCNT_MAX) ? r_wcnt : r_wcnt + LW_W'(1);

    // A new frame start restarts the line count before this word's line end
    assign w_lines_next = (frame_start_i ? 16'd0 : r_lines) + {15'd0, line_end_i};

    // Flush position decode; a zero line length means a single terminating word
    assign w_fl_last_word = (r_fl_word == r_line_words - LW_W'(1));
    assign w_fl_last_line = (r_fl_line == C_FL_LAST);

    // Frame sequencer: forwarding, line capture, flush generation, all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_px_data    <= '0;
            r_px_val     <= '0;
            r_ls         <= 1'b0;
            r_le         <= 1'b0;
            r_fs         <= 1'b0;
            r_fe         <= 1'b0;
            r_busy       <= 1'b0;
            r_flush      <= 1'b0;
            r_drop       <= 1'b0;
            r_wcnt       <= '0;
            r_line_words <= '0;
            r_fl_word    <= '0;
            r_fl_line    <= '0;
            r_lines      <= '0;
            r_line_cnt   <= '0;
            r_last_mask  <= '0;
        end else begin
            r_px_data <= '0;
            r_px_val  <= '0;
            r_ls      <= 1'b0;
            r_le      <= 1'b0;
            r_fs      <= 1'b0;
            r_fe      <= 1'b0;
            r_busy    <= 1'b0;
            r_flush   <= 1'b0;
            r_drop    <= w_drop;

            case (r_state)
                S_IDLE, S_ACTIVE: begin
                    if (w_accept) begin
                        r_px_data <= px_data_i;
                        r_px_val  <= px_data_val_i;
                        r_ls      <= line_start_i;
                        r_le      <= line_end_i;
                        r_fs      <= frame_start_i;
                        r_fe      <= frame_end_i;
                        r_busy    <= 1'b1;
                        r_wcnt    <= w_wcnt_next;
                        r_lines   <= w_lines_next;
                        r_state   <= S_ACTIVE;
                        if (line_end_i) begin
                            r_line_words <= w_wcnt_next;
                            r_last_mask  <= px_data_val_i;
                        end
                        if (frame_end_i) begin
                            r_line_cnt <= w_lines_next;
                            if (FLUSH_LINES > 0) begin
                                // Frame end is re-issued on the last synthetic word
                                r_fe      <= 1'b0;
                                r_fl_word <= '0;
                                r_fl_line <= '0;
                                r_state   <= S_FLUSH;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (r_state == S_ACTIVE) begin
                        // Aborted by a disabled frame start
                        r_lines <= '0;
                        r_state <= S_IDLE;
                    end
                end

                S_FLUSH: begin
                    r_flush <= 1'b1;
                    r_busy  <= 1'b1;
                    if (r_line_words == '0) begin
                        r_fe    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_px_val <= w_fl_last_word ? r_last_mask : '1;
                        r_ls     <= (r_fl_word == '0);
                        r_le     <= w_fl_last_word;
                        if (w_fl_last_word) begin
                            r_fl_word <= '0;
                            if (w_fl_last_line) begin
                                r_fe    <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_fl_line <= r_fl_line + FL_W'(1);
                            end
                        end else begin
                            r_fl_word <= r_fl_word + LW_W'(1);
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign px_data_o     = r_px_data;
    assign px_data_val_o = r_px_val;
    assign line_start_o  = r_ls;
    assign line_end_o    = r_le;
    assign frame_start_o = r_fs;
    assign frame_end_o   = r_fe;
    assign busy_o        = r_busy;
    assign flush_o       = r_flush;
    assign frame_drop_o  = r_drop;
    assign line_cnt_o    = r_line_cnt;
    assign line_words_o  = r_line_words;

endmodule
`default_nettype wire

// File: tb/tb_video_window_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_window_flush_ctrl
// Purpose  : Scoreboard bench for video_window_flush_ctrl. Stimulus pushes the
//            expected output words and drop pulses with their cycle stamps;
//            a monitor pops and compares whenever the DUT presents output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_window_flush_ctrl;

    localparam int DW   = 48;
    localparam int LW_W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, en_i;
    logic [DW-1:0]   px_data_i;
    logic [3:0]      px_data_val_i;
    logic            line_start_i, line_end_i, frame_start_i, frame_end_i;

    logic [DW-1:0]   px_data_o;
    logic [3:0]      px_data_val_o;
    logic            line_start_o, line_end_o, frame_start_o, frame_end_o;
    logic            busy_o, flush_o, frame_drop_o;
    logic [15:0]     line_cnt_o;
    logic [LW_W-1:0] line_words_o;

    logic [DW-1:0]   z_px_data_o;
    logic [3:0]      z_px_data_val_o;
    logic            z_line_start_o, z_line_end_o, z_frame_start_o, z_frame_end_o;
    logic            z_busy_o, z_flush_o, z_frame_drop_o;
    logic [15:0]     z_line_cnt_o;
    logic [LW_W-1:0] z_line_words_o;

    video_window_flush_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .px_data_i(px_data_i), .px_data_val_i(px_data_val_i),
        .line_start_i(line_start_i), .line_end_i(line_end_i),
        .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
        .px_data_o(px_data_o), .px_data_val_o(px_data_val_o),
        .line_start_o(line_start_o), .line_end_o(line_end_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .busy_o(busy_o), .flush_o(flush_o), .frame_drop_o(frame_drop_o),
        .line_cnt_o(line_cnt_o), .line_words_o(line_words_o)
    );

    video_window_flush_ctrl #(.FLUSH_LINES(0)) dut_nofl (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .px_data_i(px_data_i), .px_data_val_i(px_data_val_i),
        .line_start_i(line_start_i), .line_end_i(line_end_i),
        .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
        .px_data_o(z_px_data_o), .px_data_val_o(z_px_data_val_o),
        .line_start_o(z_line_start_o), .line_end_o(z_line_end_o),
        .frame_start_o(z_frame_start_o), .frame_end_o(z_frame_end_o),
        .busy_o(z_busy_o), .flush_o(z_flush_o), .frame_drop_o(z_frame_drop_o),
        .line_cnt_o(z_line_cnt_o), .line_words_o(z_line_words_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] stamp;
        logic [57:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];

    function automatic logic [57:0] pk(input logic [DW-1:0] d, input logic [3:0] v,
                                       input logic ls, input logic le, input logic fs,
                                       input logic fe, input logic fl, input logic bz);
        return {d, v, ls, le, fs, fe, fl, bz};
    endfunction

    function automatic logic [DW-1:0] pix(input int l, input int w);
        return {12'(l), 12'(w), 12'(l + w), 12'hA5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input int stamp, input logic [57:0] w);
        exp_t e;
        e.stamp = 32'(stamp);
        e.w     = w;
        exp_q.push_back(e);
    endtask

    logic [57:0] w_act;
    assign w_act = pk(px_data_o, px_data_val_o, line_start_o, line_end_o,
                      frame_start_o, frame_end_o, flush_o, busy_o);

    // Monitor: compare every presented output word and every drop pulse
    always @(negedge clk) begin
        exp_t e;
        if ((|px_data_val_o) | line_start_o | line_end_o | frame_start_o | frame_end_o | flush_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h at cycle %0d, required no output", w_act, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("word", {6'd0, w_act}, {6'd0, e.w});
                chk("word_cycle", 64'(cyc), 64'(e.stamp));
            end
        end
        if (frame_drop_o) begin
            if (drop_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_drop: got pulse at cycle %0d, required none", cyc);
            end else begin
                chk("drop_cycle", 64'(cyc), 64'(drop_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic [3:0] v, input logic ls,
                         input logic le, input logic fs, input logic fe, input logic en);
        @(negedge clk);
        px_data_i     = d;
        px_data_val_i = v;
        line_start_i  = ls;
        line_end_i    = le;
        frame_start_i = fs;
        frame_end_i   = fe;
        en_i          = en;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Drive a frame of nl lines x nw words; en0 is applied on the frame start
    // word only (en_i is high afterwards). stop_line truncates the frame.
    task automatic send_frame(input int nw, input int nl, input logic [3:0] lm, input logic en0,
                              input bit fwd, input bit exp_drop, input int stop_line,
                              input int fl_limit, input bit chk_idle, output int fe_stamp);
        logic [3:0]    v;
        logic          ls, le, fs, fe;
        logic [DW-1:0] d;
        fe_stamp = -1;
        for (int l = 0; l < nl; l++) begin
            if (l == stop_line) break;
            for (int w = 0; w < nw; w++) begin
                v  = (w == nw - 1) ? lm : 4'hF;
                ls = (w == 0);
                le = (w == nw - 1);
                fs = (l == 0) && (w == 0);
                fe = (l == nl - 1) && (w == nw - 1);
                d  = pix(l, w);
                drive(d, v, ls, le, fs, fe, fs ? en0 : 1'b1);
                if (chk_idle) chk("busy_disabled", 64'(busy_o), 64'd0);
                if (fs && exp_drop) drop_q.push_back(cyc + 1);
                if (fwd) push_exp(cyc + 1, pk(d, v, ls, le, fs, 1'b0, 1'b0, 1'b1));
                if (fe) fe_stamp = cyc + 1;
            end
            if (l < nl - 1) idle(1);
        end
        if (fwd && fe_stamp >= 0) begin
            for (int i = 0; i < nw && (fl_limit < 0 || i < fl_limit); i++)
                push_exp(fe_stamp + 1 + i,
                         pk('0, (i == nw - 1) ? lm : 4'hF, i == 0, i == nw - 1,
                            1'b0, i == nw - 1, 1'b1, 1'b1));
        end
    endtask

    initial begin
        int s;
        rst_i = 1'b1;
        en_i = 1'b0; px_data_i = '0; px_data_val_i = '0;
        line_start_i = 1'b0; line_end_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_px_data", 64'(px_data_o), 64'd0);
        chk("rst_px_val", 64'(px_data_val_o), 64'd0);
        chk("rst_markers", 64'({line_start_o, line_end_o, frame_start_o, frame_end_o}), 64'd0);
        chk("rst_busy_flush_drop", 64'({busy_o, flush_o, frame_drop_o}), 64'd0);
        chk("rst_line_cnt", 64'(line_cnt_o), 64'd0);
        chk("rst_line_words", 64'(line_words_o), 64'd0);
        rst_i = 1'b0;
        idle(2);

        // 1936-wide frame, 4 lines: 484-word flush line
        send_frame(484, 4, 4'hF, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        idle(1);
        chk("nofl_frame_end", 64'(z_frame_end_o), 64'd1);
        chk("nofl_last_val", 64'(z_px_data_val_o), 64'hF);
        idle(1);
        chk("nofl_busy_after", 64'({z_busy_o, z_flush_o, z_frame_end_o}), 64'd0);
        idle(486);
        chk("line_cnt_1936", 64'(line_cnt_o), 64'd4);
        chk("line_words_1936", 64'(line_words_o), 64'd484);

        // 1938-wide frame: partial last word mask 0011
        send_frame(485, 2, 4'b0011, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        idle(490);
        chk("line_cnt_1938", 64'(line_cnt_o), 64'd2);
        chk("line_words_1938", 64'(line_words_o), 64'd485);

        // Disabled frame start, enable raised mid-frame: nothing forwarded
        send_frame(8, 3, 4'hF, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1, s);
        idle(3);
        chk("busy_after_disabled", 64'(busy_o), 64'd0);
        send_frame(8, 3, 4'h7, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        idle(12);
        chk("line_cnt_8x3", 64'(line_cnt_o), 64'd3);

        // Frame start during flush: dropped, flush still completes
        send_frame(8, 2, 4'hF, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        send_frame(8, 3, 4'hF, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0, s);
        idle(4);
        chk("drop_keeps_line_cnt", 64'(line_cnt_o), 64'd2);
        chk("drop_keeps_line_words", 64'(line_words_o), 64'd8);
        send_frame(6, 5, 4'h1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        idle(10);
        chk("line_cnt_after_drop", 64'(line_cnt_o), 64'd5);
        chk("line_words_after_drop", 64'(line_words_o), 64'd6);

        // Abort at line 10 by an enabled frame start: no flush, count restarts
        send_frame(6, 12, 4'hF, 1'b1, 1'b1, 1'b0, 10, -1, 1'b0, s);
        send_frame(5, 3, 4'h3, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0, s);
        idle(10);
        chk("line_cnt_after_abort", 64'(line_cnt_o), 64'd3);
        chk("line_words_after_abort", 64'(line_words_o), 64'd5);

        // Abort by a disabled frame start: back to IDLE, new frame discarded
        send_frame(7, 4, 4'hF, 1'b1, 1'b1, 1'b0, 2, -1, 1'b0, s);
        send_frame(6, 3, 4'hF, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, s);
        idle(2);
        chk("busy_after_abort_off", 64'(busy_o), 64'd0);
        chk("line_cnt_abort_off", 64'(line_cnt_o), 64'd3);
        chk("line_words_abort_off", 64'(line_words_o), 64'd7);

        // Reset at flush word 100 of a 200-word flush line
        send_frame(200, 2, 4'hF, 1'b1, 1'b1, 1'b0, -1, 100, 1'b0, s);
        for (int k = 0; k < 400 && cyc < s + 100; k++) idle(1);
        chk("reset_point_reached", 64'(cyc), 64'(s + 100));
        rst_i = 1'b1;
        idle(1);
        chk("midrst_outputs", 64'({busy_o, flush_o, frame_end_o, line_end_o, frame_drop_o}), 64'd0);
        chk("midrst_val", 64'(px_data_val_o), 64'd0);
        chk("midrst_line_words", 64'(line_words_o), 64'd0);
        chk("midrst_line_cnt", 64'(line_cnt_o), 64'd0);
        rst_i = 1'b0;
        idle(2);
        send_frame(4, 2, 4'hF, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, s);
        idle(8);
        chk("line_cnt_post_reset", 64'(line_cnt_o), 64'd2);

        idle(4);
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("drop_queue_drained", 64'(drop_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_window_flush_ctrl.md
# video_window_flush_ctrl

Frame sequencer placed directly in front of `video_stream_to_window`. It admits whole frames under an enable, and forwards the video stream to the window block with one cycle of latency. After each frame it appends `FLUSH_LINES` synthetic zero lines so the window line buffers drain the bottom border rows before `frame_end_o` is asserted. It also reports per-frame geometry and flags dropped or aborted frames.

## Interface
- `PX_WIDTH`, 12, bits per pixel
- `PX_PER_CLK`, 4, pixels per stream word
- `WIN_SIZE`, 3, window size of the downstream window block
- `MAX_LINE_SIZE`, 1936, maximum pixels per line
- `FLUSH_LINES`, `WIN_SIZE/2`, synthetic lines appended per frame (0 allowed)
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, synchronous, active-high
- `en_i` in 1: frame admit enable, sampled only on `frame_start_i`
- `px_data_i` in `PX_PER_CLK*PX_WIDTH`: pixel word
- `px_data_val_i` in `PX_PER_CLK`: per-pixel valid
- `line_start_i`, `line_end_i`, `frame_start_i`, `frame_end_i` in 1 each: stream markers, qualified by the word they accompany
- `px_data_o`, `px_data_val_o`, `line_start_o`, `line_end_o`, `frame_start_o`, `frame_end_o` out: stream to the window block, same widths as the inputs
- `busy_o` out 1: high while state is not IDLE
- `flush_o` out 1: high while synthetic words are being emitted
- `frame_drop_o` out 1: one-cycle pulse per dropped or aborted frame
- `line_cnt_o` out 16: number of real lines in the last completed frame
- `line_words_o` out `$clog2(ceil(MAX_LINE_SIZE/PX_PER_CLK)+1)`: word count of the last captured real line

## Operation
- States: IDLE, ACTIVE, FLUSH.
- **IDLE**
  - Outputs are zero.
  - `frame_start_i` with `en_i`=1 moves the block to ACTIVE, and that word is forwarded.
  - `frame_start_i` with `en_i`=0 ignores the whole frame.
  - All other input is discarded.
- **ACTIVE: forwarding**
  - Every input word is registered to the output unchanged, including all-zero-valid blanking words.
  - The word counter clears on `line_start_i`, counts each word of the line, and saturates at its maximum.
- **ACTIVE: line capture**
  - On `line_end_i`, the block latches the line's word count into `line_words_o` and `px_data_val_i` into LAST_MASK.
  - It also increments the internal line counter.
- **ACTIVE: frame end**
  - If `FLUSH_LINES`>0: `frame_end_i` is forwarded with `frame_end_o` forced to 0, `line_cnt_o` is updated, and the block moves to FLUSH.
  - If `FLUSH_LINES`=0: `frame_end_o` is forwarded, `line_cnt_o` is updated, and the block moves to IDLE.
- **ACTIVE: new frame start (abort)**
  - `frame_start_i` while in ACTIVE pulses `frame_drop_o`.
  - The line counter resets, and the new frame is forwarded without a flush for the aborted frame (`en_i` is re-sampled).
  - If `en_i`=0, the block returns to IDLE and the new frame's start word is not forwarded.
- **FLUSH: emitted lines**
  - Emits `FLUSH_LINES` lines of `line_words_o` words each, back-to-back at one word per clock with no gap between lines.
  - `px_data_o` is 0.
  - `px_data_val_o` is all ones, except the last word of each line, which uses LAST_MASK.
  - `line_start_o` marks the first word of each line and `line_end_o` the last; a 1-word line carries both.
  - `frame_end_o` accompanies the last word of the last line, then the block moves to IDLE.
- **FLUSH: input handling**
  - Input is ignored during FLUSH.
  - `frame_start_i` during FLUSH pulses `frame_drop_o` once; that frame is discarded entirely.
- If `line_words_o`=0 at FLUSH entry (no line_end seen), FLUSH emits one word carrying `frame_end_o` with zero valid, then the block returns to IDLE.

## Timing
- Reset: every output is 0, state is IDLE, and the counters, LAST_MASK and `line_words_o` are 0.
- Reset applied mid-operation: outputs are 0 on the following cycle, with no `frame_end_o`.
- Forward latency is exactly 1 cycle.
- The first flush word appears the cycle after the output word that corresponds to `frame_end_i`.
- Flush duration is `FLUSH_LINES*line_words_o` cycles.
- `busy_o` and `flush_o` are registered and aligned with the output words.
- `frame_drop_o` rises 1 cycle after the offending `frame_start_i`.
- `line_cnt_o` and `line_words_o` are valid from the cycle after the capturing word and hold until the next capture.

## Test plan
- **Full frame, 1936x1096, 4 px/clk, `en_i`=1**
  - Output equals input delayed 1 cycle, with `frame_end_o` suppressed on the real last word.
  - Next come 484 zero words with `line_start_o` on the first and `line_end_o`+`frame_end_o` on the last.
  - `line_cnt_o`=1096, `line_words_o`=484.
- **RES_X=1938**
  - 485 words per line; the last real word and the last flush word both have `px_data_val_o`=4'b0011.
- **`en_i` handling**
  - `en_i`=0 at `frame_start_i`: zero output for the whole frame and `busy_o`=0.
  - `en_i` raised mid-frame: nothing is forwarded until the next `frame_start_i`.
- **`frame_start_i` during FLUSH**
  - `frame_drop_o` pulses for 1 cycle and the flush still completes with `frame_end_o`.
  - That frame is not forwarded; the following frame is forwarded normally.
- **`frame_start_i` at line 10 of an active frame**
  - `frame_drop_o` pulses, there is no flush, `frame_start_o` follows 1 cycle later, and the line count restarts.
- **Edge cases**
  - `FLUSH_LINES`=0: `frame_end_o` is forwarded directly.
  - `rst_i` at flush word 100: all outputs 0 next cycle, `busy_o`=0, no `frame_end_o`.
